// File: rtl/sipo_deser_pkg.sv
// sipo_pkg: shared constants, frame-length helper and holding-buffer type for
// the sipo_deser serial-in / parallel-out deserializer.
//
// Build option: define SIPO_PARITY_EN to append one even-parity bit to every
// frame; without it a frame is exactly WIDTH data bits.
//
// Contents:
//   SIPO_WIDTH_DEF  default data width (bits per word)
//   SIPO_PARITY_ON  1 when the parity build is selected
//   sipo_frame()    serial bits per frame for a given width / parity option
//   sipo_hold_t     holding-buffer entry {data, par_err} at the default width
package sipo_pkg;

   localparam int SIPO_WIDTH_DEF = 4;

`ifdef SIPO_PARITY_EN
   localparam bit SIPO_PARITY_ON = 1'b1;
`else
   localparam bit SIPO_PARITY_ON = 1'b0;
`endif

   function automatic int sipo_frame(input int width, input bit parity_en);
      return parity_en ? width + 1 : width;
   endfunction

   typedef struct packed {
      logic [SIPO_WIDTH_DEF-1:0] data;
      logic                      par_err;
   } sipo_hold_t;

endpackage

// File: rtl/sipo_deser_hold_buf.sv
// sipo_hold_buf: one-entry valid/ready holding buffer for completed words.
//
// A word offered on load is taken when the buffer is empty or is being
// drained on the same edge (no bubble on back-to-back words). A word offered
// while the buffer is full and not draining is dropped and the sticky
// overrun flag is raised; only flush or reset clears it. flush leaves the
// buffered word and its valid flag alone.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      clears overrun
//   load       a completed word is offered this edge
//   load_word  the offered entry {data, par_err}
//   ready      consumer accepts the held word when valid & ready
//   word       held entry
//   valid      held entry not yet consumed
//   overrun    sticky: an offered word was dropped
module sipo_hold_buf
   import sipo_pkg::*;
#(
   parameter type hold_t = sipo_hold_t
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  flush,
   input  logic  load,
   input  hold_t load_word,
   input  logic  ready,
   output hold_t word,
   output logic  valid,
   output logic  overrun
);

   logic take;

   // Free, or emptying on this very edge.
   assign take = load & (~valid | ready);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word    <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (take) begin
            word  <= load_word;
            valid <= 1'b1;
         end else if (valid & ready) begin
            valid <= 1'b0;
         end

         if (flush) begin
            overrun <= 1'b0;
         end else if (load & ~take) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in, parallel-out deserializer. Collects an MSB-first
// framed bit stream into WIDTH-bit words and hands each finished word to a
// one-deep valid/ready holding buffer so shifting continues while the
// consumer stalls.
//
// Build option: SIPO_PARITY_EN adds a trailing even-parity bit to each frame;
// par_err then reports the XOR of all WIDTH+1 received bits for the word on
// pout. Without it par_err is constant 0. The port list is the same in both
// builds.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   sin         serial data bit
//   sin_valid   sin is sampled on this edge
//   flush       discards the partial word and clears overrun (wins over sin)
//   pout        completed word, MSB = first bit received
//   pout_valid  pout holds an unconsumed word
//   pout_ready  consumer accepts pout when pout_valid & pout_ready
//   overrun     sticky: a completed word was dropped
//   par_err     parity error for the word on pout
module sipo_deser
   import sipo_pkg::*;
#(
   parameter int WIDTH = SIPO_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             flush,
   output logic [WIDTH-1:0] pout,
   output logic             pout_valid,
   input  logic             pout_ready,
   output logic             overrun,
   output logic             par_err
);

   localparam int FRAME = sipo_frame(WIDTH, SIPO_PARITY_ON);
   localparam int CNT_W = $clog2(FRAME + 1);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             par_err;
   } hold_t;

   // The completing bit is taken straight from sin, so the register only
   // needs the bits received before it: WIDTH-1 without parity, all WIDTH
   // data bits when the parity bit closes the frame.
`ifdef SIPO_PARITY_EN
   localparam int SH_W = WIDTH;
`else
   localparam int SH_W = WIDTH - 1;
`endif

   logic [SH_W-1:0]  shreg;
   logic [CNT_W-1:0] bit_cnt;
   logic             shift;
   logic             done;
   hold_t            done_word;
   hold_t            held;

   assign shift = sin_valid & ~flush;
   assign done  = shift & (bit_cnt == CNT_W'(FRAME - 1));

`ifdef SIPO_PARITY_EN
   assign done_word.data    = shreg;
   assign done_word.par_err = ^{shreg, sin};
`else
   assign done_word.data    = {shreg, sin};
   assign done_word.par_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (flush) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (sin_valid) begin
         // Oldest bit falls off the top; the word is rebuilt every frame.
         shreg   <= SH_W'({shreg, sin});
         bit_cnt <= done ? '0 : bit_cnt + 1'b1;
      end
   end

   sipo_hold_buf #(
      .hold_t (hold_t)
   ) u_hold (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .load      (done),
      .load_word (done_word),
      .ready     (pout_ready),
      .word      (held),
      .valid     (pout_valid),
      .overrun   (overrun)
   );

   assign pout    = held.data;
   assign par_err = held.par_err;

endmodule

// File: tb/tb_sipo_deser.sv
// Testbench for sipo_deser (default WIDTH = 4). Works for both the plain and
// the SIPO_PARITY_EN build; the parity-specific scenario is compiled only in
// the parity build.
`timescale 1ns/1ps
module tb_sipo_deser;

   localparam int WIDTH = 4;
`ifdef SIPO_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             sin = 1'b0;
   logic             sin_valid = 1'b0;
   logic             flush = 1'b0;
   logic             pout_ready = 1'b0;
   logic [WIDTH-1:0] pout;
   logic             pout_valid;
   logic             overrun;
   logic             par_err;

   int n_checks = 0;
   int n_pass   = 0;

   // Expected words in delivery order: {par_err, data}.
   logic [WIDTH:0] exp_q[$];

   always #5 clk = ~clk;

   sipo_deser #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .sin        (sin),
      .sin_valid  (sin_valid),
      .flush      (flush),
      .pout       (pout),
      .pout_valid (pout_valid),
      .pout_ready (pout_ready),
      .overrun    (overrun),
      .par_err    (par_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_checks++;
      if (obs === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
   endtask

   // Called at the negedge with inputs already set for the coming edge:
   // a handshake seen here is the one that happens on that edge.
   task automatic monitor();
      logic [WIDTH:0] e;
      if (pout_valid && pout_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_word", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("sb_pout", 32'(pout), 32'(e[WIDTH-1:0]));
            check("sb_par_err", 32'(par_err), 32'(e[WIDTH]));
         end
      end
   endtask

   task automatic cycle();
      monitor();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [WIDTH-1:0] w, input bit perr);
      exp_q.push_back({perr & PAR, w});
   endtask

   task automatic send_bit(input logic b);
      sin       = b;
      sin_valid = 1'b1;
      cycle();
      sin_valid = 1'b0;
      sin       = 1'b0;
   endtask

   // Sends one frame MSB first (plus parity bit in the parity build, with
   // perr inverting it). gap inserts an idle cycle between bits; ready_last
   // raises pout_ready just before the final bit of the frame.
   task automatic send_word(input logic [WIDTH-1:0] w, input bit perr,
                            input bit gap, input bit ready_last);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (ready_last && !PAR && i == 0) pout_ready = 1'b1;
         send_bit(w[i]);
         if (gap && (i != 0 || PAR)) cycle();
      end
      if (PAR) begin
         if (ready_last) pout_ready = 1'b1;
         send_bit((^w) ^ perr);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_pout", 32'(pout), 32'd0);
      check("rst_valid", 32'(pout_valid), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_par_err", 32'(par_err), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // 1: back-to-back bits, consumer ready
      pout_ready = 1'b1;
      push(4'b1011, 1'b0);
      send_word(4'b1011, 1'b0, 1'b0, 1'b0);
      check("t1_valid", 32'(pout_valid), 32'd1);
      check("t1_pout", 32'(pout), 32'hb);
      check("t1_overrun", 32'(overrun), 32'd0);
      cycle();
      check("t1_valid_one_cycle", 32'(pout_valid), 32'd0);

      // 2: gaps between bits
      push(4'b1011, 1'b0);
      send_word(4'b1011, 1'b0, 1'b1, 1'b0);
      check("t2_valid", 32'(pout_valid), 32'd1);
      check("t2_pout", 32'(pout), 32'hb);
      cycle();
      check("t2_valid_drop", 32'(pout_valid), 32'd0);

      // 3: stalled consumer, second word dropped
      pout_ready = 1'b0;
      push(4'b1011, 1'b0);
      send_word(4'b1011, 1'b0, 1'b0, 1'b0);
      check("t3_overrun_first", 32'(overrun), 32'd0);
      send_word(4'b0110, 1'b0, 1'b0, 1'b0);
      check("t3_pout_held", 32'(pout), 32'hb);
      check("t3_valid_held", 32'(pout_valid), 32'd1);
      check("t3_overrun", 32'(overrun), 32'd1);
      pout_ready = 1'b1;
      cycle();
      check("t3_valid_accepted", 32'(pout_valid), 32'd0);
      check("t3_overrun_sticky", 32'(overrun), 32'd1);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      check("t3_overrun_flushed", 32'(overrun), 32'd0);
      check("t3_pout_after_flush", 32'(pout), 32'hb);

      // 4: completion coincides with acceptance
      pout_ready = 1'b0;
      push(4'b1100, 1'b0);
      send_word(4'b1100, 1'b0, 1'b0, 1'b0);
      check("t4_valid_first", 32'(pout_valid), 32'd1);
      push(4'b0011, 1'b0);
      send_word(4'b0011, 1'b0, 1'b0, 1'b1);
      check("t4_valid_no_bubble", 32'(pout_valid), 32'd1);
      check("t4_pout_second", 32'(pout), 32'h3);
      check("t4_overrun", 32'(overrun), 32'd0);
      cycle();
      check("t4_valid_drop", 32'(pout_valid), 32'd0);

      // 5a: flush mid-word with a simultaneous bit
      send_bit(1'b1);
      send_bit(1'b0);
      sin       = 1'b1;
      sin_valid = 1'b1;
      flush     = 1'b1;
      cycle();
      flush     = 1'b0;
      sin_valid = 1'b0;
      sin       = 1'b0;
      check("t5_no_word_after_flush", 32'(pout_valid), 32'd0);
      push(4'b0101, 1'b0);
      send_word(4'b0101, 1'b0, 1'b0, 1'b0);
      check("t5_valid", 32'(pout_valid), 32'd1);
      check("t5_pout", 32'(pout), 32'h5);
      cycle();

      // 5b: asynchronous reset mid-word with a word buffered and overrun set
      pout_ready = 1'b0;
      push(4'b1110, 1'b0);
      send_word(4'b1110, 1'b0, 1'b0, 1'b0);
      send_word(4'b0001, 1'b0, 1'b0, 1'b0);
      check("t5_pre_rst_overrun", 32'(overrun), 32'd1);
      send_bit(1'b1);
      send_bit(1'b0);
      #2 reset = 1'b0;
      #1;
      check("t5_rst_pout", 32'(pout), 32'd0);
      check("t5_rst_valid", 32'(pout_valid), 32'd0);
      check("t5_rst_overrun", 32'(overrun), 32'd0);
      check("t5_rst_par_err", 32'(par_err), 32'd0);
      exp_q.delete();
      #1 reset = 1'b1;
      @(negedge clk);
      pout_ready = 1'b1;
      push(4'b1001, 1'b0);
      send_word(4'b1001, 1'b0, 1'b0, 1'b0);
      check("t5_new_frame_valid", 32'(pout_valid), 32'd1);
      cycle();

`ifdef SIPO_PARITY_EN
      // 6: parity frames
      push(4'b1011, 1'b0);
      for (int i = WIDTH - 1; i >= 0; i--) send_bit(4'b1011 >> i);
      check("t6_no_valid_before_parity", 32'(pout_valid), 32'd0);
      send_bit(1'b1);
      check("t6_valid", 32'(pout_valid), 32'd1);
      check("t6_par_ok", 32'(par_err), 32'd0);
      cycle();
      push(4'b1011, 1'b1);
      send_word(4'b1011, 1'b1, 1'b0, 1'b0);
      check("t6_par_err", 32'(par_err), 32'd1);
      check("t6_pout", 32'(pout), 32'hb);
      cycle();
`endif

      pout_ready = 1'b0;
      cycle();
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Serial-in, parallel-out deserializer: the receive-side counterpart of the team's 4-bit PISO shift register.
- Collects a framed serial bit stream, MSB first, into WIDTH-bit words.
- Presents each completed word on a valid/ready output with a one-deep holding buffer, so shifting continues while the consumer stalls.
- Sits between a serial link endpoint and parallel datapath logic.

Parameters:
- WIDTH, 4, data bits per word (≥2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this edge when 1.
- flush  input  1  synchronous; discards the partial word in the shift register.
- pout  output  WIDTH  completed word; MSB = first bit received.
- pout_valid  output  1  pout holds an unconsumed word.
- pout_ready  input  1  consumer accepts pout when pout_valid & pout_ready.
- overrun  output  1  sticky; a completed word was dropped.
- par_err  output  1  parity error for the word on pout; tied 0 without the optional feature.

Behaviour:
- Reset (reset=0, async): shift register, bit counter, pout, pout_valid, overrun and par_err all clear to 0.
- Shifting:
  - On each edge with sin_valid=1 and flush=0: shreg <= {shreg[WIDTH-2:0], sin}; bit_cnt increments.
  - sin_valid=0 holds all state; gaps between bits are allowed.
- Word completion:
  - Occurs on the edge where sin_valid=1 and bit_cnt = FRAME-1, where FRAME = WIDTH (or WIDTH+1 with the parity feature).
  - bit_cnt wraps to 0.
- Transfer to the holding buffer: on the completion edge, if the buffer is free (pout_valid=0) or draining (pout_valid & pout_ready):
  - pout <= completed word; pout_valid <= 1.
  - Latency: pout_valid is high in the cycle after the last bit's sampling edge.
- Acceptance: pout_valid & pout_ready with no simultaneous completion → pout_valid <= 0 next edge; pout holds its last value.
- Simultaneous completion and acceptance: the buffer reloads with the new word and pout_valid stays 1 with no bubble.
- Overrun:
  - Completion while pout_valid=1 and pout_ready=0 → the new word is dropped; pout and pout_valid are unchanged; overrun <= 1.
  - overrun clears only on reset or flush.
- Flush:
  - Clears bit_cnt, shreg and overrun.
  - Does not touch pout, pout_valid or par_err; a buffered word remains deliverable.
  - Flush and sin_valid on the same edge: flush wins and the bit is discarded.
- Reset mid-word: the partial word and the buffered word are both lost; the next bit starts a new frame.
- Implicit states: bit_cnt acts as the frame state (FILL 0..FRAME-1); the holding buffer is EMPTY or FULL via pout_valid.
- Widths: bit_cnt is $clog2(FRAME+1) bits.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Frame = WIDTH data bits followed by 1 even-parity bit.
  - The parity bit is not shifted into pout.
  - On completion, par_err for that word = XOR of all WIDTH+1 received bits; it is loaded alongside pout and dropped with the word on overrun.
  - Completion occurs on the parity bit.
- Undefined: frame = WIDTH bits and par_err is constant 0.
- The port list is identical in both builds.

Decomposition:
- Package sipo_pkg holds:
  - Default width constant SIPO_WIDTH_DEF = 4.
  - A function computing FRAME from WIDTH and the parity option.
  - typedef of the holding-buffer struct {data, par_err}.
- One sub-module is natural: sipo_hold_buf, the one-entry valid/ready buffer with the drop-on-full/overrun logic.
- The shift register and bit counter stay in sipo_deser.

Test Plan:
1. Reset release, then sin = 1,0,1,1 with sin_valid high on 4 consecutive edges and pout_ready=1 → pout=4'b1011, pout_valid high for exactly 1 cycle after the 4th edge; overrun=0.
2. Same word 1011 with sin_valid toggling 1,0,1,0,... → identical pout; pout_valid rises 1 cycle after the 4th sampled bit.
3. pout_ready=0:
   - Send 1011 then 0110 → pout stays 1011, pout_valid=1, overrun=1 after the 8th bit.
   - Then pout_ready=1 → accepted, pout_valid=0.
   - Then flush → overrun=0.
4. Back-to-back words 1100, 0011 with pout_ready asserted exactly on the cycle the second word completes → pout_valid stays 1 continuously and pout changes 1100→0011.
5. After 2 bits (1,0), flush=1 together with sin_valid=1, then send 0101 → pout=4'b0101; the partial bits and the flush-edge bit are discarded. Separately, reset=0 pulsed mid-word → all outputs 0 immediately (async).
6. SIPO_PARITY_EN build:
   - 1011 + parity 1 → pout=1011, par_err=0.
   - 1011 + parity 0 → par_err=1.
   - pout_valid rises only after the 5th bit.
